dmem_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single-port data memory: combinational read, synchronous write, word-indexed by address>>2. It arbitrates between the instruction-fetch requester (port 0) and the load/store requester (port 1) with round-robin priority. It drives the memory control signals for exactly one access cycle per transaction and returns a registered response over a valid/ready handshake. It sits between the core's fetch/LSU stages and the data memory.

---
 rtl/dmem_pkg.sv | 10 +
 rtl/dmem_arbiter_rr.sv | 8 +
 rtl/dmem_arbiter.sv | 108 ++++++++++
 tb/tb_dmem_arbiter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding, alignment mask and request record for the data-memory arbiter
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
  } req_t;
endpackage

// File: rtl/dmem_arbiter_rr.sv
// rr_arbiter2: combinational two-way round-robin picker; on contention the requester that did not win last time gets the grant
module rr_arbiter2 (
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);
  always_comb grant_o = &valid_i ? (last_grant_i ? 2'b01 : 2'b10) : valid_i;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter and one-access sequencer between fetch (port 0) and LSU (port 1) and a single-port data memory
module dmem_arbiter import dmem_pkg::*; #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter bit RESET_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req0_we,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp0_err,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic              req1_we,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              rsp1_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_read_data
);
  if (DATA_W != 32) begin : g_dw_chk
    $error("dmem_arbiter: DATA_W must be 32");
  end
  if (ADDR_W < 3 || ADDR_W > 32) begin : g_aw_chk
    $error("dmem_arbiter: ADDR_W must be in 3..32");
  end
  state_e            state_q, state_d;
  req_t              req_q, req_d;
  logic              gnt_q, gnt_d, last_q, last_d, err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        grant;
  logic              aligned, rsp_ready;
  rr_arbiter2 u_arb (
    .valid_i      ({req1_valid, req0_valid}),
    .last_grant_i (last_q),
    .grant_o      (grant)
  );
  assign aligned   = (req_q.addr[1:0] & WORD_ALIGN_MASK) == 2'b00;
  assign rsp_ready = gnt_q ? rsp1_ready : rsp0_ready;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= '0;
      gnt_q   <= 1'b0;
      last_q  <= ~RESET_PRIO;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (state_q == IDLE && |grant) begin
      state_d     = ACCESS;
      gnt_d       = grant[1];
      last_d      = grant[1];
      req_d.addr  = grant[1] ? 32'(req1_addr) : 32'(req0_addr);
      req_d.wdata = grant[1] ? req1_wdata : req0_wdata;
      req_d.we    = grant[1] ? req1_we : req0_we;
    end else if (state_q == ACCESS) begin
      state_d = RESP;
      rdata_d = (aligned && !req_q.we) ? mem_read_data : '0;
      err_d   = !aligned;
    end else if (state_q == RESP && rsp_ready) begin
      state_d = IDLE;
      rdata_d = '0;
      err_d   = 1'b0;
    end
  end
  // Ready is masked during reset so the ports show reset values even while requests are held.
  always_comb begin
    req0_ready     = state_q == IDLE && grant[0] && !reset;
    req1_ready     = state_q == IDLE && grant[1] && !reset;
    rsp0_valid     = state_q == RESP && !gnt_q;
    rsp1_valid     = state_q == RESP && gnt_q;
    rsp0_rdata     = gnt_q ? '0 : rdata_q;
    rsp1_rdata     = gnt_q ? rdata_q : '0;
    rsp0_err       = err_q && !gnt_q;
    rsp1_err       = err_q && gnt_q;
    mem_address    = req_q.addr[ADDR_W-1:0];
    mem_write_data = req_q.wdata;
    mem_read       = state_q == ACCESS && aligned && !req_q.we;
    mem_write      = state_q == ACCESS && aligned && req_q.we;
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of arbitration, sequencing, backpressure, misalignment and mid-access reset
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  rv, rwe, rspr;
  logic [31:0] ra [2];
  logic [31:0] rwd [2];
  wire  [1:0]  rr, rspv, rerr;
  wire  [31:0] rrd [2];
  wire  [31:0] mem_address, mem_write_data, mem_read_data;
  wire         mem_read, mem_write;
  logic [31:0] mem [64];
  int          checks, errors;

  dmem_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .req0_valid     (rv[0]),
    .req0_ready     (rr[0]),
    .req0_addr      (ra[0]),
    .req0_wdata     (rwd[0]),
    .req0_we        (rwe[0]),
    .rsp0_valid     (rspv[0]),
    .rsp0_ready     (rspr[0]),
    .rsp0_rdata     (rrd[0]),
    .rsp0_err       (rerr[0]),
    .req1_valid     (rv[1]),
    .req1_ready     (rr[1]),
    .req1_addr      (ra[1]),
    .req1_wdata     (rwd[1]),
    .req1_we        (rwe[1]),
    .rsp1_valid     (rspv[1]),
    .rsp1_ready     (rspr[1]),
    .rsp1_rdata     (rrd[1]),
    .rsp1_err       (rerr[1]),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_read_data  (mem_read_data)
  );

  always #5 clk = ~clk;
  assign mem_read_data = mem[mem_address[7:2]];
  always @(posedge clk) if (mem_write) mem[mem_address[7:2]] <= mem_write_data;

  function automatic logic [31:0] onehot(input int p);
    return 32'(1) << p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Uncontended transaction on port p; entered and left in IDLE at posedge+2.
  task automatic txn(input int p, input logic [31:0] a, input logic [31:0] wd, input logic we,
                     input logic [31:0] exp_rd);
    logic ok;
    ok = a[1:0] == 2'b00;
    rv[p] = 1'b1; ra[p] = a; rwd[p] = wd; rwe[p] = we; #1;
    chk("req_ready", 32'(rr), onehot(p));
    chk("idle_mem_ctl", 32'({mem_read, mem_write}), 32'd0);
    @(posedge clk); #1;
    rv[p] = 1'b0; ra[p] = 32'hFFFF_FFFF; rwd[p] = 32'h0; rwe[p] = ~we; #1;
    chk("access_mem_ctl", 32'({mem_read, mem_write}), 32'({ok & ~we, ok & we}));
    chk("access_addr", mem_address, a);
    chk("access_wdata", mem_write_data, wd);
    chk("access_ready", 32'(rr), 32'd0);
    chk("access_rsp_valid", 32'(rspv), 32'd0);
    @(posedge clk); #1;
    chk("rsp_valid", 32'(rspv), onehot(p));
    chk("rsp_rdata", rrd[p], exp_rd);
    chk("rsp_err", 32'(rerr), ok ? 32'd0 : onehot(p));
    chk("rsp_mem_ctl", 32'({mem_read, mem_write}), 32'd0);
    rspr[p] = 1'b1;
    @(posedge clk); #1;
    rspr[p] = 1'b0; #1;
    chk("rsp_done", 32'(rspv), 32'd0);
  endtask

  initial begin
    checks = 0; errors = 0;
    rv = 2'b11; rwe = 2'b00; rspr = 2'b00;
    ra[0] = 32'h0; ra[1] = 32'h0; rwd[0] = 32'h0; rwd[1] = 32'h0;
    for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
    mem[4]  <= 32'hDEAD_BEEF;
    mem[12] <= 32'h1234_5678;
    reset = 1'b1; #1;
    chk("rst_ready", 32'(rr), 32'd0);
    chk("rst_rsp_valid", 32'(rspv), 32'd0);
    chk("rst_rsp_err", 32'(rerr), 32'd0);
    chk("rst_rdata0", rrd[0], 32'd0);
    chk("rst_rdata1", rrd[1], 32'd0);
    chk("rst_mem_ctl", 32'({mem_read, mem_write}), 32'd0);
    chk("rst_mem_addr", mem_address, 32'd0);
    chk("rst_mem_wdata", mem_write_data, 32'd0);
    @(posedge clk); #1;
    rv = 2'b00; reset = 1'b0;
    @(posedge clk); #1;
    // single read, then write/read-back on the LSU port
    txn(0, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF);
    txn(1, 32'h20, 32'hCAFE_F00D, 1'b1, 32'h0);
    chk("write_commit", mem[8], 32'hCAFE_F00D);
    txn(1, 32'h20, 32'h0, 1'b0, 32'hCAFE_F00D);
    // contention: port 1 won last, so grants alternate starting with port 0
    rspr = 2'b11; rv = 2'b11; rwe = 2'b00; ra[0] = 32'h10; ra[1] = 32'h20;
    for (int k = 0; k < 8; k++) begin
      int g;
      g = k % 2;
      #1;
      chk("cont_grant", 32'(rr), onehot(g));
      @(posedge clk); #1;
      chk("cont_access_ready", 32'(rr), 32'd0);
      @(posedge clk); #1;
      chk("cont_rsp", 32'(rspv), onehot(g));
      chk("cont_rdata", rrd[g], g == 1 ? 32'hCAFE_F00D : 32'hDEAD_BEEF);
      @(posedge clk); #1;
    end
    rv = 2'b00; rspr = 2'b00; #1;
    // backpressure on rsp0 while req1 waits
    rv[0] = 1'b1; ra[0] = 32'h10; rwe[0] = 1'b0; #1;
    chk("bp_grant0", 32'(rr), 32'd1);
    @(posedge clk); #1;
    rv[0] = 1'b0; rv[1] = 1'b1; ra[1] = 32'h20; rwe[1] = 1'b0; #1;
    chk("bp_access_ready", 32'(rr), 32'd0);
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      chk("bp_rsp_valid", 32'(rspv), 32'd1);
      chk("bp_rsp_rdata", rrd[0], 32'hDEAD_BEEF);
      chk("bp_req1_ready", 32'(rr), 32'd0);
      @(posedge clk); #1;
    end
    rspr[0] = 1'b1; #1;
    chk("bp_hs_ready", 32'(rr), 32'd0);
    @(posedge clk); #1;
    rspr[0] = 1'b0; #1;
    chk("bp_req1_granted", 32'(rr), 32'd2);
    chk("bp_rsp_cleared", 32'(rspv), 32'd0);
    @(posedge clk); #1;
    rv[1] = 1'b0;
    @(posedge clk); #1;
    chk("bp_rsp1_valid", 32'(rspv), 32'd2);
    chk("bp_rsp1_rdata", rrd[1], 32'hCAFE_F00D);
    rspr[1] = 1'b1;
    @(posedge clk); #1;
    rspr[1] = 1'b0; #1;
    // misaligned store must not touch memory
    txn(0, 32'h13, 32'h1111_1111, 1'b1, 32'h0);
    chk("misaligned_mem", mem[4], 32'hDEAD_BEEF);
    // reset during the access cycle of a store
    rv[1] = 1'b1; ra[1] = 32'h30; rwd[1] = 32'hBAD0_BAD0; rwe[1] = 1'b1; #1;
    chk("mid_grant", 32'(rr), 32'd2);
    @(posedge clk); #1;
    rv[1] = 1'b0; #1;
    chk("mid_access_write", 32'(mem_write), 32'd1);
    reset = 1'b1; #1;
    chk("mid_rst_mem_ctl", 32'({mem_read, mem_write}), 32'd0);
    chk("mid_rst_mem_addr", mem_address, 32'd0);
    chk("mid_rst_mem_wdata", mem_write_data, 32'd0);
    chk("mid_rst_rsp", 32'(rspv), 32'd0);
    @(posedge clk); #1;
    chk("mid_rst_mem_kept", mem[12], 32'h1234_5678);
    chk("mid_rst_rsp_held", 32'(rspv), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    rv = 2'b11; ra[0] = 32'h30; ra[1] = 32'h10; rwe = 2'b00; #1;
    chk("post_rst_prio", 32'(rr), 32'd1);
    rv = 2'b00; #1;
    txn(0, 32'h30, 32'h0, 1'b0, 32'h1234_5678);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
